tow_cyber_player: RTL and testbench

- Computer opponent for the tug-of-war game.
- Generates the player-2 "press" pulse that feeds tow_delegator's player2 input.
- Replaces the free-running LFSR plus comparator pair with one block that adds:
  - a difficulty threshold,
  - a one-cycle pulse guarantee,
  - a cooldown that stops the cyber player from pressing on consecutive cycles.
- Runs on the divided game clock alongside tow_input.

---
 rtl/tow_cyber_player.sv | 104 ++++++++++
 tb/tb_tow_cyber_player.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_cyber_player.sv
// Computer opponent for tug-of-war: an LFSR is compared against a difficulty threshold
// to fire one-cycle player-2 press pulses, with an enforced cooldown between presses.
module tow_cyber_player #(
    parameter int unsigned       WIDTH    = 10,
    parameter logic [WIDTH-1:0]  SEED     = 10'h001,
    parameter int unsigned       COOLDOWN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-2:0] difficulty,
    output logic             press,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPress,
        StCooldown
    } state_e;

    localparam logic [3:0]       CoolLoad = 4'(COOLDOWN - 1);
    localparam logic [WIDTH-1:0] LfsrOne  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] lfsr_d;
    logic             hit;

    // Taps WIDTH-1 and WIDTH-4 give x^10+x^7+1 at the default width; zero is escaped.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            if (lfsr_q == '0) begin
                lfsr_d = LfsrOne;
            end else begin
                lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-4]};
            end
        end
    end

    assign hit = ({1'b0, difficulty} > lfsr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // A dropped enable outranks a simultaneous hit.
                if (!enable) begin
                    state_d = StIdle;
                end else if (hit) begin
                    state_d = StPress;
                end
            end
            StPress: begin
                if (enable) begin
                    state_d = StCooldown;
                    cnt_d   = CoolLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StCooldown: begin
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StArmed;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Pure decode of the state register: no combinational path from any input.
    assign press = (state_q == StPress);
    assign busy  = (state_q == StPress) || (state_q == StCooldown);

endmodule

// File: tb/tb_tow_cyber_player.sv
// Self-checking bench for tow_cyber_player: table-driven LFSR vectors plus a scoreboard
// fed by a small behavioural model, and hand sequences for enable/reset corner cases.
module tb_tow_cyber_player;

    localparam int W  = 10;
    localparam int CD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         en2;
    logic [W-2:0] difficulty;
    logic         press, busy;
    logic [W-1:0] lfsr_q;
    logic         press2, busy2;
    logic [W-1:0] lfsr2;

    always #5 clk = ~clk;

    tow_cyber_player #(
        .WIDTH   (W),
        .SEED    (10'h001),
        .COOLDOWN(CD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .difficulty(difficulty),
        .press     (press),
        .lfsr_q    (lfsr_q),
        .busy      (busy)
    );

    tow_cyber_player #(
        .WIDTH   (W),
        .SEED    (10'h000),
        .COOLDOWN(CD)
    ) u_seed0 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en2),
        .difficulty(9'd0),
        .press     (press2),
        .lfsr_q    (lfsr2),
        .busy      (busy2)
    );

    typedef struct packed {
        logic         press;
        logic         busy;
        logic [W-1:0] lfsr;
    } exp_t;

    typedef struct {
        logic         en;
        logic [W-2:0] diff;
        logic [W-1:0] lfsr;
        logic         press;
        logic         busy;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    // Behavioural reference: 0 idle, 1 armed, 2 press, 3 cooldown.
    int           m_state;
    logic [W-1:0] m_lfsr;
    int           m_cnt;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        if (v == '0) return 10'h001;
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic model_edge(input logic en, input logic [W-2:0] diff);
        logic hit;
        hit = ({1'b0, diff} > m_lfsr);
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 0; else if (hit) m_state = 2;
            2: begin
                if (en) begin
                    m_state = 3;
                    m_cnt   = CD - 1;
                end else begin
                    m_state = 0;
                end
            end
            default: begin
                if (!en) begin
                    m_state = 0;
                    m_cnt   = 0;
                end else if (m_cnt == 0) begin
                    m_state = 1;
                end else begin
                    m_cnt--;
                end
            end
        endcase
        if (en) m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({press, busy, lfsr_q} !== {e.press, e.busy, e.lfsr}) begin
            failures++;
            $display("FAIL %s: got press=%0b busy=%0b lfsr=%0h required press=%0b busy=%0b lfsr=%0h",
                     tag, press, busy, lfsr_q, e.press, e.busy, e.lfsr);
        end
    endtask

    task automatic step(input logic en, input logic [W-2:0] diff, input string tag);
        exp_t e;
        enable     = en;
        difficulty = diff;
        model_edge(en, diff);
        e.press = (m_state == 2);
        e.busy  = (m_state == 2) || (m_state == 3);
        e.lfsr  = m_lfsr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sb_compare(tag);
    endtask

    task automatic step_vec(input vec_t v, input string tag);
        exp_t e;
        enable     = v.en;
        difficulty = v.diff;
        model_edge(v.en, v.diff);
        e.press = v.press;
        e.busy  = v.busy;
        e.lfsr  = v.lfsr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sb_compare(tag);
    endtask

    vec_t vecs[11];

    initial begin
        int           n_press;
        int           last;
        int           min_gap;
        int           consec;
        logic         prev;
        logic         any_press;
        logic         found;
        logic [W-1:0] frz;

        vecs[0]  = '{1'b1, 9'd2, 10'd2,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 9'd2, 10'd4,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 9'd2, 10'd8,   1'b0, 1'b0};
        vecs[3]  = '{1'b1, 9'd2, 10'd16,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 9'd2, 10'd32,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 9'd2, 10'd64,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 9'd2, 10'd129, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 9'd2, 10'd258, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 9'd2, 10'd516, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 9'd2, 10'd9,   1'b0, 1'b0};
        vecs[10] = '{1'b1, 9'd2, 10'd18,  1'b0, 1'b0};

        reset      = 1'b0;
        enable     = 1'b0;
        en2        = 1'b0;
        difficulty = '0;
        m_state    = 0;
        m_lfsr     = 10'h001;
        m_cnt      = 0;
        #12;
        reset = 1'b1;
        #1;
        check("reset_lfsr", lfsr_q, 10'h001);
        check("reset_press", {9'd0, press}, 10'd0);
        check("reset_busy", {9'd0, busy}, 10'd0);
        check("seed0_reset_lfsr", lfsr2, 10'h000);

        // Disabled: nothing moves even at maximum difficulty.
        for (int i = 0; i < 50; i++) step(1'b0, 9'h1FF, "disabled_hold");

        // LFSR sequence with difficulty 2: only lfsr==1 hits, after a full period.
        for (int i = 0; i < 11; i++) step_vec(vecs[i], $sformatf("lfsr_vec%0d", i + 1));
        any_press = 1'b0;
        for (int e = 12; e <= 1023; e++) begin
            step(1'b1, 9'd2, "period_run");
            any_press |= press;
        end
        check("no_press_1_1023", {9'd0, any_press}, 10'd0);
        check("lfsr_wrap_1023", lfsr_q, 10'h001);
        step(1'b1, 9'd2, "edge1024");
        check("press_after_1024", {8'd0, press, busy}, 10'd3);
        for (int i = 0; i < CD; i++) begin
            step(1'b1, 9'd2, "cooldown_busy");
            check($sformatf("cooldown%0d", i), {8'd0, press, busy}, 10'd1);
        end
        step(1'b1, 9'd2, "rearm");
        check("rearm_not_busy", {9'd0, busy}, 10'd0);

        // Max difficulty soak: spacing and pulse width.
        n_press = 0;
        last    = -1;
        min_gap = 1000000;
        consec  = 0;
        prev    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, 9'h1FF, "soak");
            if (press) begin
                if (prev) consec++;
                if (last >= 0 && (i - last) < min_gap) min_gap = i - last;
                last = i;
                n_press++;
            end
            prev = press;
        end
        checks++;
        if (min_gap < CD + 1) begin
            failures++;
            $display("FAIL soak_min_gap: got %0d required >= %0d", min_gap, CD + 1);
        end
        check("soak_consecutive", 10'(consec), 10'd0);
        checks++;
        if (n_press < 300) begin
            failures++;
            $display("FAIL soak_count: got %0d required >= 300", n_press);
        end

        // Enable drop during cooldown, then a 3-cycle gap.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 9'h1FF, "seek_cooldown");
            if (m_state == 3) found = 1'b1;
        end
        check("reached_cooldown", {8'd0, busy, press}, 10'd2);
        step(1'b0, 9'h1FF, "drop_in_cooldown");
        check("drop_idle_busy", {9'd0, busy}, 10'd0);
        frz = lfsr_q;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 9'h1FF, "gap");
            check("gap_lfsr_frozen", lfsr_q, frz);
        end
        step(1'b1, 9'd0, "resume_armed");
        check("resume_lfsr_moves", lfsr_q, lfsr_step(frz));

        // Difficulty 0 never hits; then drop enable on a hit edge.
        any_press = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b1, 9'd0, "diff0_armed");
            any_press |= press;
            if ({1'b0, 9'h1FF} > m_lfsr) found = 1'b1;
        end
        check("diff0_no_press", {9'd0, any_press}, 10'd0);
        check("hit_pending", {9'd0, found}, 10'd1);
        step(1'b0, 9'h1FF, "enable_beats_hit");
        check("enable_beats_hit_out", {8'd0, press, busy}, 10'd0);
        step(1'b0, 9'h1FF, "still_idle");

        // Asynchronous reset mid-press.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 9'h1FF, "seek_press");
            if (press) found = 1'b1;
        end
        check("press_seen", {9'd0, press}, 10'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_press_low", {8'd0, press, busy}, 10'd0);
        check("async_lfsr_seed", lfsr_q, 10'h001);
        check("async_seed0", lfsr2, 10'h000);
        enable  = 1'b0;
        m_state = 0;
        m_lfsr  = 10'h001;
        m_cnt   = 0;
        sb.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_lfsr", lfsr_q, 10'h001);

        // Lockup guard on the zero-seed instance.
        check("seed0_held", lfsr2, 10'h000);
        en2 = 1'b1;
        @(posedge clk);
        #1;
        check("seed0_escape", lfsr2, 10'h001);
        @(posedge clk);
        #1;
        check("seed0_next", lfsr2, 10'h002);
        check("seed0_no_press", {8'd0, press2, busy2}, 10'd0);
        en2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
